// File: rtl/tmds_enc_multi.sv
// tmds_enc_multi: multi-lane DVI 1.0 TMDS encoder with 2+OUT_REG cycle latency.
// Define TMDS_ENC_PATTERN_EN to add I_pattern and a per-lane ramp test pattern.
module tmds_enc_multi #(
  parameter int CHANNELS = 3,
  parameter int OUT_REG  = 1
) (
  input  logic                   I_rgb_clk,
  input  logic                   I_rst,
  input  logic                   I_de,
  input  logic [8*CHANNELS-1:0]  I_data,
  input  logic [2*CHANNELS-1:0]  I_ctrl,
`ifdef TMDS_ENC_PATTERN_EN
  input  logic                   I_pattern,
`endif
  output logic [10*CHANNELS-1:0] O_tmds,
  output logic                   O_de,
  output logic [5*CHANNELS-1:0]  O_disp
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, d[i]};
    end
    return n;
  endfunction

  function automatic logic [8:0] min_trans(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor) begin
        q[i] = ~(q[i-1] ^ d[i]);
      end else begin
        q[i] = q[i-1] ^ d[i];
      end
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      2'b11:   s = CTRL_11;
      default: s = CTRL_00;
    endcase
    return s;
  endfunction

  // Returns {next_cnt[4:0], symbol[9:0]} for one lane.
  function automatic logic [14:0] encode_lane(input logic de, input logic [1:0] ctrl,
                                              input logic [8:0] qm, input logic [4:0] cnt);
    logic [3:0]        n1q;
    logic signed [6:0] diff;
    logic signed [6:0] cnt_x;
    logic signed [6:0] q8_2;
    logic signed [6:0] q8n_2;
    logic signed [6:0] cnt_w;
    logic [9:0]        sym;
    n1q   = ones8(qm[7:0]);
    diff  = $signed({2'b00, n1q, 1'b0}) - 7'sd8;
    cnt_x = {{2{cnt[4]}}, cnt};
    q8_2  = $signed({5'b00000, qm[8], 1'b0});
    q8n_2 = $signed({5'b00000, ~qm[8], 1'b0});
    if (!de) begin
      sym   = ctrl_sym(ctrl);
      cnt_w = 7'sd0;
    end else if ((cnt == 5'd0) || (n1q == 4'd4)) begin
      sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8]) begin
        cnt_w = cnt_x + diff;
      end else begin
        cnt_w = cnt_x - diff;
      end
    end else if ((!cnt[4] && (n1q > 4'd4)) || (cnt[4] && (n1q < 4'd4))) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      cnt_w = cnt_x + q8_2 - diff;
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      cnt_w = cnt_x + diff - q8n_2;
    end
    return {cnt_w[4:0], sym};
  endfunction

  logic [8*CHANNELS-1:0]  data_s;
  logic                   de_s1_r;
  logic [2*CHANNELS-1:0]  ctrl_s1_r;
  logic [9*CHANNELS-1:0]  qm_s1_r;
  logic [15*CHANNELS-1:0] enc_s;
  logic                   de_s2_r;
  logic [10*CHANNELS-1:0] sym_s2_r;
  logic [5*CHANNELS-1:0]  cnt_r;

`ifdef TMDS_ENC_PATTERN_EN
  logic [7:0] pix_cnt_r;

  // pixel counter: advances on video cycles, clears during blanking
  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      pix_cnt_r <= 8'd0;
    end else if (I_de) begin
      pix_cnt_r <= pix_cnt_r + 8'd1;
    end else begin
      pix_cnt_r <= 8'd0;
    end
  end

  // data source: ramp offset by 64 per lane when the pattern is selected
  always_comb begin
    data_s = I_data;
    if (I_pattern) begin
      for (int k = 0; k < CHANNELS; k++) begin
        data_s[8*k +: 8] = pix_cnt_r + 8'(64 * k);
      end
    end else begin
      data_s = I_data;
    end
  end
`else
  assign data_s = I_data;
`endif

  // stage 1: transition-minimised words, control and DE alongside
  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      de_s1_r   <= 1'b0;
      ctrl_s1_r <= {(2*CHANNELS){1'b0}};
      qm_s1_r   <= {(9*CHANNELS){1'b0}};
    end else begin
      de_s1_r   <= I_de;
      ctrl_s1_r <= I_ctrl;
      for (int k = 0; k < CHANNELS; k++) begin
        qm_s1_r[9*k +: 9] <= min_trans(data_s[8*k +: 8]);
      end
    end
  end

  // stage 2 next state: per-lane DC-balance decision
  always_comb begin
    enc_s = {(15*CHANNELS){1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      enc_s[15*k +: 15] = encode_lane(de_s1_r, ctrl_s1_r[2*k +: 2],
                                      qm_s1_r[9*k +: 9], cnt_r[5*k +: 5]);
    end
  end

  // stage 2: symbol and running disparity registers
  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      de_s2_r  <= 1'b0;
      sym_s2_r <= {CHANNELS{CTRL_00}};
      cnt_r    <= {(5*CHANNELS){1'b0}};
    end else begin
      de_s2_r <= de_s1_r;
      for (int k = 0; k < CHANNELS; k++) begin
        sym_s2_r[10*k +: 10] <= enc_s[15*k +: 10];
        cnt_r[5*k +: 5]      <= enc_s[15*k+10 +: 5];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [10*CHANNELS-1:0] tmds_o_r;
      logic                   de_o_r;
      logic [5*CHANNELS-1:0]  disp_o_r;

      // optional output retiming stage
      always_ff @(posedge I_rgb_clk) begin
        if (I_rst) begin
          tmds_o_r <= {CHANNELS{CTRL_00}};
          de_o_r   <= 1'b0;
          disp_o_r <= {(5*CHANNELS){1'b0}};
        end else begin
          tmds_o_r <= sym_s2_r;
          de_o_r   <= de_s2_r;
          disp_o_r <= cnt_r;
        end
      end

      assign O_tmds = tmds_o_r;
      assign O_de   = de_o_r;
      assign O_disp = disp_o_r;
    end else begin : g_no_out_reg
      assign O_tmds = sym_s2_r;
      assign O_de   = de_s2_r;
      assign O_disp = cnt_r;
    end
  endgenerate

endmodule

// File: tb/tb_tmds_enc_multi.sv
// tb_tmds_enc_multi: directed checks of tmds_enc_multi, OUT_REG=1 and OUT_REG=0 side by side.
// Expected symbols and disparities are hand-computed from the DVI 1.0 encoding rules.
module tb_tmds_enc_multi;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;

  typedef struct packed {
    logic        de;
    logic [29:0] tmds;
    logic [14:0] disp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        de;
  logic [23:0] data;
  logic [5:0]  ctrl;
`ifdef TMDS_ENC_PATTERN_EN
  logic        pattern;
`endif
  logic [29:0] tmds1, tmds0;
  logic        de1, de0;
  logic [14:0] disp1, disp0;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  tmds_enc_multi #(.CHANNELS(3), .OUT_REG(1)) dut (
    .I_rgb_clk(clk), .I_rst(rst), .I_de(de), .I_data(data), .I_ctrl(ctrl),
`ifdef TMDS_ENC_PATTERN_EN
    .I_pattern(pattern),
`endif
    .O_tmds(tmds1), .O_de(de1), .O_disp(disp1)
  );

  tmds_enc_multi #(.CHANNELS(3), .OUT_REG(0)) dut0 (
    .I_rgb_clk(clk), .I_rst(rst), .I_de(de), .I_data(data), .I_ctrl(ctrl),
`ifdef TMDS_ENC_PATTERN_EN
    .I_pattern(pattern),
`endif
    .O_tmds(tmds0), .O_de(de0), .O_disp(disp0)
  );

  function automatic logic [14:0] pd(input int d2, input int d1, input int d0);
    return {d2[4:0], d1[4:0], d0[4:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two idle entries stand for the reset contents still in the pipeline.
  task automatic seed();
    exp_t e;
    e.de   = 1'b0;
    e.tmds = {C00, C00, C00};
    e.disp = 15'd0;
    exp_q.delete();
    exp_q.push_back(e);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic v_de, input logic [23:0] v_data, input logic [5:0] v_ctrl,
                      input logic [29:0] e_tmds, input logic [14:0] e_disp);
    exp_t e;
    int   m;
    de     = v_de;
    data   = v_data;
    ctrl   = v_ctrl;
    e.de   = v_de;
    e.tmds = e_tmds;
    e.disp = e_disp;
    exp_q.push_back(e);
    tick();
    m = exp_q.size() - 1;
    check("tmds_outreg1", 32'(tmds1), 32'(exp_q[m-2].tmds));
    check("de_outreg1",   32'(de1),   32'(exp_q[m-2].de));
    check("disp_outreg1", 32'(disp1), 32'(exp_q[m-2].disp));
    check("tmds_outreg0", 32'(tmds0), 32'(exp_q[m-1].tmds));
    check("de_outreg0",   32'(de0),   32'(exp_q[m-1].de));
    check("disp_outreg0", 32'(disp0), 32'(exp_q[m-1].disp));
  endtask

  task automatic check_reset_state();
    check("rst_tmds1", 32'(tmds1), 32'({C00, C00, C00}));
    check("rst_de1",   32'(de1),   32'd0);
    check("rst_disp1", 32'(disp1), 32'd0);
    check("rst_tmds0", 32'(tmds0), 32'({C00, C00, C00}));
    check("rst_de0",   32'(de0),   32'd0);
    check("rst_disp0", 32'(disp0), 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    de   = 1'b0;
    data = 24'd0;
    ctrl = 6'd0;
`ifdef TMDS_ENC_PATTERN_EN
    pattern = 1'b0;
`endif
    tick();
    tick();
    check_reset_state();

    rst = 1'b0;
    seed();
    // control symbols on every lane, then video with lane-specific data
    step(1'b0, 24'h000000, 6'b11_10_01, {C11, C10, C01}, 15'd0);
    step(1'b1, 24'h00FF00, 6'd0, {10'b0100000000, 10'b1000000000, 10'b0100000000}, pd(-8, -8, -8));
    step(1'b1, 24'h00FF00, 6'd0, {10'b1111111111, 10'b0011111111, 10'b1111111111}, pd(2, -2, 2));
    step(1'b1, 24'hFF0001, 6'd0, {10'b1000000000, 10'b1111111111, 10'b1100000000}, pd(-6, 8, -4));
    // blanking forces disparity back to zero
    step(1'b0, 24'h000000, 6'b00_00_10, {C00, C00, C10}, 15'd0);
    step(1'b1, 24'h000000, 6'd0, {10'b0100000000, 10'b0100000000, 10'b0100000000}, pd(-8, -8, -8));
    step(1'b1, 24'h01FF10, 6'd0, {10'b0111111111, 10'b0011111111, 10'b0111110000}, pd(0, -2, -8));
    step(1'b1, 24'h0000F0, 6'd0, {10'b0100000000, 10'b1111111111, 10'b0011111010}, pd(-8, 8, -6));
    step(1'b0, 24'h000000, 6'b10_01_11, {C10, C01, C11}, 15'd0);
    step(1'b0, 24'h000000, 6'd0, {C00, C00, C00}, 15'd0);
    step(1'b0, 24'h000000, 6'd0, {C00, C00, C00}, 15'd0);

    // mid-stream reset discards in-flight symbols and restarts disparity at zero
    step(1'b1, 24'h000000, 6'd0, {10'b0100000000, 10'b0100000000, 10'b0100000000}, pd(-8, -8, -8));
    step(1'b1, 24'h000000, 6'd0, {10'b1111111111, 10'b1111111111, 10'b1111111111}, pd(2, 2, 2));
    rst  = 1'b1;
    de   = 1'b1;
    data = 24'h123456;
    tick();
    check_reset_state();
    rst = 1'b0;
    seed();
    step(1'b1, 24'h000000, 6'd0, {10'b0100000000, 10'b0100000000, 10'b0100000000}, pd(-8, -8, -8));
    step(1'b1, 24'h000000, 6'd0, {10'b1111111111, 10'b1111111111, 10'b1111111111}, pd(2, 2, 2));
    step(1'b0, 24'h000000, 6'd0, {C00, C00, C00}, 15'd0);
    step(1'b0, 24'h000000, 6'd0, {C00, C00, C00}, 15'd0);

`ifdef TMDS_ENC_PATTERN_EN
    // ramp pattern: lanes carry count, count+64, count+128; count restarts after blanking
    pattern = 1'b1;
    step(1'b1, 24'hABCDEF, 6'd0, {10'b0110000000, 10'b0111000000, 10'b0100000000}, pd(-6, -4, -8));
    step(1'b1, 24'hABCDEF, 6'd0, {10'b0101111111, 10'b0100111111, 10'b0111111111}, pd(0, 0, 0));
    step(1'b1, 24'hABCDEF, 6'd0, {10'b0101111110, 10'b0100111110, 10'b0111111110}, pd(4, 2, 6));
    step(1'b0, 24'hABCDEF, 6'd0, {C00, C00, C00}, 15'd0);
    step(1'b1, 24'hABCDEF, 6'd0, {10'b0110000000, 10'b0111000000, 10'b0100000000}, pd(-6, -4, -8));
    pattern = 1'b0;
    step(1'b0, 24'h000000, 6'd0, {C00, C00, C00}, 15'd0);
    step(1'b0, 24'h000000, 6'd0, {C00, C00, C00}, 15'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmds_enc_multi.md
TMDS_ENC_MULTI -- requirements
Module: tmds_enc_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of independent TMDS encode lanes; legal range 1..4.
REQ-002 SHALL have parameter OUT_REG, default 1: 1 adds an output register stage; 0 omits it.
REQ-003 SHALL have port I_rgb_clk  input  1  pixel clock; the only clock.
REQ-004 SHALL have port I_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port I_de  input  1  data enable shared by all lanes; 1 = video period, 0 = control period.
REQ-006 SHALL have port I_data  input  8*CHANNELS  pixel byte per lane; lane k at [8k+7:8k].
REQ-007 SHALL have port I_ctrl  input  2*CHANNELS  control bits {C1,C0} per lane at [2k+1:2k]; lane 0 carries {vs,hs}.
REQ-008 SHALL have port O_tmds  output  10*CHANNELS  10-bit TMDS symbol per lane at [10k+9:10k]; bit 0 is serialised first.
REQ-009 SHALL have port O_de  output  1  I_de delayed to align with O_tmds.
REQ-010 SHALL have port O_disp  output  5*CHANNELS  signed two's-complement running disparity per lane after the current symbol.

Function
REQ-011 SHALL have a latency of 2+OUT_REG cycles from I_de/I_data/I_ctrl sampling to O_tmds/O_de/O_disp; lanes stay mutually aligned.
REQ-012 Stage 1 SHALL compute N1 = ones(D) and form q_m by the DVI 1.0 minimisation rule: XNOR chain when N1>4 or (N1==4 and D[0]==0), else XOR chain; q_m[8]=1 for XOR, 0 for XNOR.
REQ-013 Stage 2 SHALL, when de=1 and (cnt==0 or ones(q_m[7:0])==4): emit {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m[8] ? (N1q-N0q) : (N0q-N1q).
REQ-014 Stage 2 SHALL, when de=1 and ((cnt>0 and N1q>N0q) or (cnt<0 and N0q>N1q)): emit {1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (N0q-N1q).
REQ-015 Stage 2 SHALL, otherwise with de=1: emit {0, q_m[8], q_m[7:0]}; cnt += (N1q-N0q) - 2*(~q_m[8]).
REQ-016 When de=0, SHALL emit per lane {C1,C0}: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011 (bit 9 leftmost), and SHALL force cnt to 0.
REQ-017 cnt SHALL be 5-bit signed per lane and SHALL remain within -16..+15 without wrap; all counts are even.
REQ-018 A DE transition SHALL take effect on exactly the symbol sampled with it; no symbol is dropped or duplicated.

Reset
REQ-019 While I_rst=1 at a clock edge, SHALL clear all pipeline state; next cycle O_de=0, O_disp=0, and every lane of O_tmds=1101010100.
REQ-020 Reset mid-stream SHALL discard in-flight symbols; the first symbol after release starts with cnt=0 and emerges after the full latency.

Configuration
REQ-021 Macro TMDS_ENC_PATTERN_EN SHALL, when defined, add input port I_pattern (1 bit) and an 8-bit pixel counter.
REQ-022 With TMDS_ENC_PATTERN_EN and I_pattern=1, lane k data SHALL be replaced by (counter + 64*k) mod 256; the counter increments on each de=1 cycle and clears to 0 on any de=0 cycle and on reset.
REQ-023 Without TMDS_ENC_PATTERN_EN, I_pattern and the counter SHALL not exist; I_data is always encoded.

Verification
REQ-024 Reset, then de=0, lane0 ctrl=01 -> after 3 cycles (OUT_REG=1) lane0 O_tmds=0010101011, O_disp=0, O_de=0.
REQ-025 From cnt=0, de=1, data 0x00 twice -> O_tmds 0100000000 (disp -8), then 1111111111 (disp +2).
REQ-026 From cnt=0, de=1, data 0xFF -> O_tmds 1000000000, O_disp -8.
REQ-027 Stream random data, assert I_rst for 1 cycle mid-line -> next cycle outputs equal reset values; post-release symbols match a reference model that starts at cnt=0.
REQ-028 OUT_REG=0 vs 1 with the same stimulus -> identical symbol streams, offset by exactly 1 cycle.
REQ-029 TMDS_ENC_PATTERN_EN, I_pattern=1, de=1 for 3 cycles -> lane0 data 0x00,0x01,0x02; lane1 data 0x40,0x41,0x42; counter restarts at 0 after de=0.
